// File: rtl/muldiv_exec_unit.sv
// Multi-cycle RV32M execute slot: iterative restoring divider and a multiplier.
// Stalls the front end while busy and pulses resultValid for one cycle on retirement.
module muldiv_exec_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned DIV_RADIX_BITS = 1,
  parameter int unsigned MUL_LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [4:0]      rdAddrIn,
  output logic            stall,
  output logic            resultValid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdAddr
);

  localparam int unsigned DivIters = XLEN / DIV_RADIX_BITS;
  localparam int unsigned DivCntW  = $clog2(DivIters + 1);
  localparam int unsigned MulCntW  = $clog2(MUL_LATENCY + 1);
  localparam int unsigned CntW     = (DivCntW > MulCntW) ? DivCntW : MulCntW;
  localparam logic [CntW-1:0] MulLast = CntW'(MUL_LATENCY - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(DivIters - 1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, rem_q, res_q, result_q;
  logic [CntW-1:0] cnt_q;
  logic            neg_quo_q, neg_rem_q;
  logic [4:0]      rd_q, rdaddr_q;

  // Operand preparation for a new op
  logic            sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, early_res;

  always_comb begin
    sgn       = ~funct3[0];
    a_neg     = sgn & srcA[XLEN-1];
    b_neg     = sgn & srcB[XLEN-1];
    a_mag     = a_neg ? -srcA : srcA;
    b_mag     = b_neg ? -srcB : srcB;
    div_zero  = (srcB == '0);
    div_ovf   = sgn & (srcA == MinNeg) & (&srcB);
    if (div_zero) early_res = funct3[1] ? srcA : '1;
    else          early_res = funct3[1] ? '0 : srcA;
  end

  // Operands are sign-extended to 2*XLEN so one unsigned multiply covers all signedness cases
  logic            mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_full;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    mul_sa   = (op_q != 2'b11) & a_q[XLEN-1];
    mul_sb   = (op_q == 2'b01) & b_q[XLEN-1];
    mul_a    = {{XLEN{mul_sa}}, a_q};
    mul_b    = {{XLEN{mul_sb}}, b_q};
    mul_full = mul_a * mul_b;
    mul_res  = (op_q == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
  end

  // Restoring divider step: a_q shifts dividend bits out and quotient bits in
  logic [XLEN:0]   dv_rem;
  logic [XLEN-1:0] dv_quo, quo_fix, rem_fix, div_res;

  always_comb begin
    dv_rem = {1'b0, rem_q};
    dv_quo = a_q;
    for (int i = 0; i < DIV_RADIX_BITS; i++) begin
      dv_rem = {dv_rem[XLEN-1:0], dv_quo[XLEN-1]};
      dv_quo = {dv_quo[XLEN-2:0], 1'b0};
      if (dv_rem >= {1'b0, b_q}) begin
        dv_rem    = dv_rem - {1'b0, b_q};
        dv_quo[0] = 1'b1;
      end
    end
    quo_fix = neg_quo_q ? -dv_quo : dv_quo;
    rem_fix = neg_rem_q ? -dv_rem[XLEN-1:0] : dv_rem[XLEN-1:0];
    div_res = op_q[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= '0;
      rdaddr_q  <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q  <= funct3[1:0];
            rd_q  <= rdAddrIn;
            cnt_q <= '0;
            if (!funct3[2]) begin
              a_q     <= srcA;
              b_q     <= srcB;
              state_q <= StMul;
            end else if (div_zero || div_ovf) begin
              res_q   <= early_res;
              state_q <= StDone;
            end else begin
              a_q       <= a_mag;
              b_q       <= b_mag;
              rem_q     <= '0;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              state_q   <= StDiv;
            end
          end
        end
        StMul: begin
          if (cnt_q == MulLast) begin
            res_q   <= mul_res;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDiv: begin
          rem_q <= dv_rem[XLEN-1:0];
          a_q   <= dv_quo;
          if (cnt_q == DivLast) begin
            res_q   <= div_res;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          result_q <= res_q;
          rdaddr_q <= rd_q;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    stall       = ~rst & ~flush & (((state_q == StIdle) & start) |
                                   (state_q == StMul) | (state_q == StDiv));
    resultValid = ~rst & ~flush & (state_q == StDone);
    // The retiring value is visible in DONE; a flushed DONE never commits it
    result      = (state_q == StDone) ? res_q : result_q;
    rdAddr      = (state_q == StDone) ? rd_q : rdaddr_q;
  end

endmodule
